// File: rtl/riscv_lsu.sv
// riscv_lsu: single-outstanding load/store unit. Places bytes on a word-wide
// bus, optionally splits a boundary-crossing access into two beats, and
// assembles and extends load data.
module riscv_lsu #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    output logic              rsp_store,
    output logic [4:0]        rsp_rd,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_err
);
    localparam int BW = XLEN / 8;
    localparam int OW = $clog2(BW);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    typedef struct packed {
        logic              store;
        logic [1:0]        size;
        logic              uns;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   wdata;
        logic [4:0]        rd;
    } req_t;

    logic [2:0]      state;
    req_t            r;
    logic            cross_q;
    logic [XLEN-1:0] rbuf0, rbuf1;

    // acceptance-time classification of the incoming request
    logic [4:0] in_end;
    logic       in_cross, in_illegal;
    assign in_end     = 5'(req_addr[OW-1:0]) + (5'd1 << req_size);
    assign in_cross   = in_end > 5'(BW);
    assign in_illegal = (req_size == 2'b11 && XLEN == 32) || (in_cross && MISALIGN_SPLIT == 0);

    // lane placement over a two-beat window; beat1 takes the upper half
    logic [OW-1:0]       off;
    logic [3:0]          nbytes;
    logic [2*BW-1:0]     be_all;
    logic [2*XLEN-1:0]   wd_all;
    logic [ADDR_W-1:0]   aligned;
    logic [XLEN-1:0]     ld_raw, ld_ext, keep;
    logic                sb;
    assign off     = r.addr[OW-1:0];
    assign nbytes  = 4'd1 << r.size;
    assign be_all  = (2*BW)'((16'd1 << nbytes) - 16'd1) << off;
    assign wd_all  = {{XLEN{1'b0}}, r.wdata} << {off, 3'b000};
    assign aligned = {r.addr[ADDR_W-1:OW], {OW{1'b0}}};
    assign ld_raw  = XLEN'({rbuf1, rbuf0} >> {off, 3'b000});

    // truncate the assembled load to its size and extend
    always_comb begin
        keep = '1;
        sb   = 1'b0;
        case (r.size)
            2'b00:   begin keep = XLEN'(8'hFF);         sb = ld_raw[7];  end
            2'b01:   begin keep = XLEN'(16'hFFFF);      sb = ld_raw[15]; end
            2'b10:   begin keep = XLEN'(32'hFFFF_FFFF); sb = ld_raw[31]; end
            default: ;
        endcase
        ld_ext = (ld_raw & keep) | ((sb && !r.uns) ? ~keep : '0);
    end

    // bus and response outputs decoded from state; zero when not meaningful
    always_comb begin
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_be        = '0;
        mem_wdata     = '0;
        case (state)
            S_REQ0: begin
                mem_req_valid = 1'b1;
                mem_we        = r.store;
                mem_addr      = aligned;
                mem_be        = be_all[BW-1:0];
                mem_wdata     = wd_all[XLEN-1:0];
            end
            S_REQ1: begin
                mem_req_valid = 1'b1;
                mem_we        = r.store;
                mem_addr      = aligned + ADDR_W'(BW);
                mem_be        = be_all[2*BW-1:BW];
                mem_wdata     = wd_all[2*XLEN-1:XLEN];
            end
            default: ;
        endcase
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_DONE) || (state == S_ERR);
        rsp_err   = (state == S_ERR);
        rsp_store = rsp_valid && r.store;
        rsp_rd    = rsp_valid ? r.rd : 5'd0;
        rsp_data  = (state == S_DONE && !r.store) ? ld_ext : '0;
    end

    // request latch, beat sequencing and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            r       <= '0;
            cross_q <= 1'b0;
            rbuf0   <= '0;
            rbuf1   <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    r.store <= req_store;
                    r.size  <= req_size;
                    r.uns   <= req_unsigned;
                    r.addr  <= req_addr;
                    r.wdata <= req_wdata;
                    r.rd    <= req_rd;
                    cross_q <= in_cross;
                    state   <= in_illegal ? S_ERR : S_REQ0;
                end
                S_REQ0: if (mem_req_ready) state <= S_WAIT0;
                S_WAIT0: if (mem_rsp_valid) begin
                    if (!r.store) rbuf0 <= mem_rdata;
                    state <= cross_q ? S_REQ1 : S_DONE;
                end
                S_REQ1: if (mem_req_ready) state <= S_WAIT1;
                S_WAIT1: if (mem_rsp_valid) begin
                    if (!r.store) rbuf1 <= mem_rdata;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
